// File: rtl/input_request_arbiter_if.sv
// rtl/input_request_arbiter_if.sv - requester / input-unit bus for the input request arbiter
// Purpose: bundles the requester handshake and the input-unit handshake seen by the arbiter.
// Signals:
//   req            requester -> arbiter, level request per requester, held until ack
//   ack            arbiter -> requester, one-hot one-cycle data-valid pulse
//   rsp_data       arbiter -> requester, returned input word (valid in ack cycle)
//   grant_id       arbiter -> observer, current grantee (valid while busy)
//   busy           arbiter -> observer, transaction in flight
//   input_enable   arbiter -> input unit, one-cycle start pulse
//   input_complete input unit -> arbiter, level, 1 after user enter
//   keypad_data    input unit -> arbiter, keypad value
//   switch_data    input unit -> arbiter, switch value
//   switch_enable  input unit -> arbiter, 1 selects switch_data
//   pause_active   input unit -> arbiter, freezes completion handling
// Modports: slave = arbiter side, master = requesters plus input unit side.
interface input_request_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    ack;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  busy;
  logic                  input_enable;
  logic                  input_complete;
  logic [DATA_WIDTH-1:0] keypad_data;
  logic [DATA_WIDTH-1:0] switch_data;
  logic                  switch_enable;
  logic                  pause_active;

  modport slave (
    input  req, input_complete, keypad_data, switch_data, switch_enable, pause_active,
    output ack, rsp_data, grant_id, busy, input_enable
  );

  modport master (
    output req, input_complete, keypad_data, switch_data, switch_enable, pause_active,
    input  ack, rsp_data, grant_id, busy, input_enable
  );
endinterface

// File: rtl/input_request_arbiter.sv
// rtl/input_request_arbiter.sv - round-robin arbiter sharing the keypad/switch input unit
// Purpose: grants one requester at a time, pulses input_enable, waits for the user's enter,
//   then returns the keypad or switch word to the grantee with a one-cycle ack.
// Ports:
//   clk    system clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    input_request_arbiter_if.slave (requester and input-unit handshakes)
module input_request_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  input_request_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_ack;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic                  r_busy;
  logic                  r_input_enable;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_pick;
  int                    w_idx;
  logic [NUM_REQ-1:0]    w_shift;
  logic [NUM_REQ-1:0]    w_grant_shift;
  logic                  w_grantee_req;
  logic [NUM_REQ-1:0]    w_grant_onehot;
  logic [ID_WIDTH-1:0]   w_next_ptr;

  // Round-robin pick: scan offsets from the highest down so the smallest offset
  // from r_rr_ptr that has a request is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    w_shift = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx   = (int'(r_rr_ptr) + i) % NUM_REQ;
      w_shift = bus.req >> w_idx;
      if (w_shift[0]) begin
        w_found = 1'b1;
        w_pick  = ID_WIDTH'(w_idx);
      end
    end
  end

  assign w_grant_shift  = bus.req >> r_grant_id;
  assign w_grantee_req  = w_grant_shift[0];
  assign w_grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
  assign w_next_ptr     = (r_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_ack          <= '0;
      r_rsp_data     <= '0;
      r_grant_id     <= '0;
      r_rr_ptr       <= '0;
      r_busy         <= 1'b0;
      r_input_enable <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= '0;
          if (w_found) begin
            r_grant_id     <= w_pick;
            r_busy         <= 1'b1;
            // Registered so the pulse lands exactly in the START cycle.
            r_input_enable <= 1'b1;
            r_state        <= S_START;
          end
        end
        S_START: begin
          r_input_enable <= 1'b0;
          r_state        <= S_ARM;
        end
        S_ARM: begin
          // A completion still high from the previous transaction is stale.
          if (!bus.input_complete) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.input_complete && !bus.pause_active) begin
            r_rsp_data <= bus.switch_enable ? bus.switch_data : bus.keypad_data;
            // Ack is registered into the DONE cycle; a grantee that has dropped
            // its request gets no ack and the word is discarded.
            if (w_grantee_req) begin
              r_ack <= w_grant_onehot;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ack    <= '0;
          r_rr_ptr <= w_next_ptr;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_ack          <= '0;
          r_busy         <= 1'b0;
          r_input_enable <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack          = r_ack;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = r_busy;
  assign bus.input_enable = r_input_enable;

endmodule

// File: tb/tb_input_request_arbiter.sv
// tb/tb_input_request_arbiter.sv - scoreboard bench for input_request_arbiter
module tb_input_request_arbiter;
  localparam int NUM_REQ    = 2;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 3;

  typedef struct {
    logic [NUM_REQ-1:0]    ack;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   auto_drop = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  input_request_arbiter_if #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) bus_if ();

  input_request_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (bus_if.ack !== '0) begin
      check("ack_with_enable", 64'(bus_if.input_enable), 64'd0);
      if (sb.size() == 0) begin
        check("ack_unexpected", 64'(bus_if.ack), 64'd0);
      end else begin
        e = sb.pop_front();
        check("ack_id", 64'(bus_if.ack), 64'(e.ack));
        check("rsp_data", 64'(bus_if.rsp_data), 64'(e.data));
      end
      if (auto_drop) bus_if.req = bus_if.req & ~bus_if.ack;
    end
  end

  function automatic exp_t mk(input int id, input logic [DATA_WIDTH-1:0] d);
    exp_t x;
    x.ack  = NUM_REQ'(1) << id;
    x.data = d;
    return x;
  endfunction

  task automatic wait_enable(input int exp_id);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.input_enable !== 1'b1 && n < 20);
    check("enable_seen", 64'(bus_if.input_enable), 64'd1);
    check("grant_id", 64'(bus_if.grant_id), 64'(exp_id));
    check("busy_on_grant", 64'(bus_if.busy), 64'd1);
  endtask

  task automatic user_input(input logic [DATA_WIDTH-1:0] kp, input logic swe,
                            input logic [DATA_WIDTH-1:0] swd, input int exp_id);
    @(posedge clk); #1;
    bus_if.input_complete = 1'b0;
    @(negedge clk);
    check("enable_one_cycle", 64'(bus_if.input_enable), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    bus_if.keypad_data    = kp;
    bus_if.switch_data    = swd;
    bus_if.switch_enable  = swe;
    bus_if.input_complete = 1'b1;
    sb.push_back(mk(exp_id, swe ? swd : kp));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.busy !== 1'b0 && n < 20);
    check("busy_fall", 64'(bus_if.busy), 64'd0);
  endtask

  initial begin
    bus_if.req            = 2'b11;
    bus_if.input_complete = 1'b0;
    bus_if.keypad_data    = '0;
    bus_if.switch_data    = '0;
    bus_if.switch_enable  = 1'b0;
    bus_if.pause_active   = 1'b0;

    // Reset held with both requests pending.
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(bus_if.ack), 64'd0);
    check("rst_rsp", 64'(bus_if.rsp_data), 64'd0);
    check("rst_grant", 64'(bus_if.grant_id), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_enable", 64'(bus_if.input_enable), 64'd0);
    rst_n = 1'b1;

    // Continuous 2'b11: grants alternate 0,1,0,1, then 0 once bit 1 drops.
    wait_enable(0); user_input(32'h11, 1'b0, 32'h0, 0);         wait_idle();
    wait_enable(1); user_input(32'h0, 1'b1, 32'hA5, 1);         wait_idle();
    wait_enable(0); user_input(32'h22, 1'b1, 32'h5A, 0);        wait_idle();
    auto_drop = 1'b1;
    wait_enable(1); user_input(32'h33, 1'b0, 32'hFF, 1);        wait_idle();
    wait_enable(0); user_input(32'h44, 1'b1, 32'hDEAD_BEEF, 0); wait_idle();
    check("req_cleared", 64'(bus_if.req), 64'd0);

    // Single requester 0, keypad value 123.
    bus_if.req = 2'b01;
    wait_enable(0); user_input(32'd123, 1'b0, 32'h0, 0); wait_idle();

    // Stale completion: input_complete still 1 from last transaction.
    bus_if.req = 2'b10;
    wait_enable(1);
    repeat (5) @(negedge clk);
    check("stale_busy", 64'(bus_if.busy), 64'd1);
    @(posedge clk); #1 bus_if.input_complete = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus_if.switch_enable  = 1'b0;
    bus_if.keypad_data    = 32'd777;
    bus_if.input_complete = 1'b1;
    sb.push_back(mk(1, 32'd777));
    wait_idle();

    // Pause holds the WAIT state while complete is high.
    bus_if.req = 2'b01;
    wait_enable(0);
    @(posedge clk); #1;
    bus_if.input_complete = 1'b0;
    bus_if.pause_active   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_if.keypad_data    = 32'h55;
    bus_if.input_complete = 1'b1;
    repeat (4) @(negedge clk);
    check("pause_busy", 64'(bus_if.busy), 64'd1);
    @(posedge clk); #1;
    bus_if.pause_active = 1'b0;
    bus_if.keypad_data  = 32'h66;
    sb.push_back(mk(0, 32'h66));
    @(negedge clk);
    check("ack_not_early", 64'(bus_if.ack), 64'd0);
    @(negedge clk);
    check("ack_after_pause", 64'(bus_if.ack), 64'd1);
    wait_idle();

    // Requester 1 drops its request in WAIT: no ack, busy still falls.
    bus_if.req = 2'b10;
    wait_enable(1);
    @(posedge clk); #1 bus_if.input_complete = 1'b0;
    @(posedge clk); #1 bus_if.req = 2'b00;
    @(posedge clk); #1 bus_if.input_complete = 1'b1;
    wait_idle();

    // Asynchronous reset while in WAIT.
    bus_if.req = 2'b01;
    wait_enable(0);
    @(posedge clk); #1 bus_if.input_complete = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus_if.busy), 64'd0);
    check("arst_enable", 64'(bus_if.input_enable), 64'd0);
    check("arst_ack", 64'(bus_if.ack), 64'd0);
    check("arst_grant", 64'(bus_if.grant_id), 64'd0);
    bus_if.req = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 64'(bus_if.busy), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
